// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial word transmit path.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset_L,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_COUNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_reg;

    assign tick     = (count_reg == LAST_COUNT);
    // One cycle early, so the owner can register a pulse aligned with tick.
    assign pre_tick = (count_reg == PRE_COUNT);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count_reg <= '0;
        end else if (restart || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Framed parallel-to-serial transmitter: start, WIDTH data bits, even parity, stop.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    tx_state_t        state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             parity_reg;
    logic [IW-1:0]    bit_idx_reg;
    logic             serial_reg;
    logic             done_reg;
    logic             tick;
    logic             pre_tick;
    logic             accept;
    logic             head_bit;
    logic             next_head_bit;

    assign ready      = (state_reg == IDLE);
    assign busy       = !ready;
    assign accept     = valid && ready;
    assign serial_out = serial_reg;
    assign done       = done_reg;

    // head_bit goes on the line now; next_head_bit is what appears after a shift.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shift_next    = {1'b0, shift_reg[WIDTH-1:1]};
            assign head_bit      = shift_reg[0];
            assign next_head_bit = shift_reg[1];
        end else begin : g_msb_first
            assign shift_next    = {shift_reg[WIDTH-2:0], 1'b0};
            assign head_bit      = shift_reg[WIDTH-1];
            assign next_head_bit = shift_reg[WIDTH-2];
        end
    endgenerate

    // Held in restart while idle so the start bit gets a full period from the accept edge.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock    (clock),
        .reset_L  (reset_L),
        .restart  (ready),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg   <= IDLE;
            serial_reg  <= LINE_IDLE;
            done_reg    <= 1'b0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            bit_idx_reg <= '0;
        end else begin
            done_reg <= (state_reg == STOP) && pre_tick;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg   <= data_in;
                        parity_reg  <= ^data_in;
                        bit_idx_reg <= '0;
                        state_reg   <= START;
                        serial_reg  <= START_LEVEL;
                    end
                end
                START: begin
                    if (tick) begin
                        state_reg  <= DATA;
                        serial_reg <= head_bit;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= shift_next;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == LAST_BIT) begin
                            state_reg  <= PARITY;
                            serial_reg <= parity_reg;
                        end else begin
                            serial_reg <= next_head_bit;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_reg  <= STOP;
                        serial_reg <= STOP_LEVEL;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_reg  <= IDLE;
                        serial_reg <= LINE_IDLE;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    serial_reg <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx (WIDTH=8, CLKS_PER_BIT=4), LSB- and MSB-first instances.
module tb_serial_word_tx;

    logic       clock   = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid   = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic ready0, busy0, done0, so0;
    logic ready1, busy1, done1, so1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    serial_word_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) u_lsb (
        .clock      (clock),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid      (valid),
        .ready      (ready0),
        .serial_out (so0),
        .busy       (busy0),
        .done       (done0)
    );

    serial_word_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) u_msb (
        .clock      (clock),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid      (valid),
        .ready      (ready1),
        .serial_out (so1),
        .busy       (busy1),
        .done       (done1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Frame bits listed first-sent in bit 10, each stretched to 4 clocks.
    function automatic logic [43:0] expand(input logic [10:0] f);
        logic [43:0] r;
        r = '0;
        for (int b = 0; b < 11; b++)
            for (int c = 0; c < 4; c++)
                r[43 - (b * 4 + c)] = f[10 - b];
        return r;
    endfunction

    task automatic accept_word(input logic [7:0] w);
        @(negedge clock);
        data_in = w;
        valid   = 1'b1;
        @(posedge clock);
        #1 valid = 1'b0;
    endtask

    // Samples the 44 cycles after the accept edge; optionally pulses valid at cycle pulse_at.
    task automatic capture(input bit msb_dut, input int pulse_at,
                           output logic [43:0] line, output logic [43:0] dline);
        line  = '0;
        dline = '0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clock);
            if (i == pulse_at) begin
                valid   = 1'b1;
                data_in = 8'hFF;
            end else if (i == pulse_at + 1) begin
                valid = 1'b0;
            end
            line[43 - i]  = msb_dut ? so1 : so0;
            dline[43 - i] = msb_dut ? done1 : done0;
        end
    endtask

    task automatic post_frame(input string tag, input bit msb_dut);
        @(negedge clock);
        check({tag, "_ready_after"}, msb_dut ? ready1 : ready0, 1'b1);
        check({tag, "_busy_after"},  msb_dut ? busy1 : busy0, 1'b0);
        check({tag, "_line_after"},  msb_dut ? so1 : so0, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] w, input logic [10:0] frame,
                             input bit msb_dut, input int pulse_at);
        logic [43:0] line, dline;
        accept_word(w);
        capture(msb_dut, pulse_at, line, dline);
        check({tag, "_line"}, line, expand(frame));
        check({tag, "_done"}, dline, 44'd1);
        post_frame(tag, msb_dut);
        $display("[TB] frame %s word=%02h line=%011h", tag, w, line);
    endtask

    initial begin
        logic [43:0] line, dline;
        int busy_cycles;

        // Reset state, then idle with valid low: no transfer.
        @(negedge clock);
        check("rst_line",  so0,    1'b1);
        check("rst_ready", ready0, 1'b1);
        check("rst_busy",  busy0,  1'b0);
        check("rst_done",  done0,  1'b0);
        reset_L = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (busy0) busy_cycles++;
        end
        check("idle_no_valid", busy_cycles, 0);
        $display("[TB] reset and idle checked");

        run_frame("a5",     8'hA5, 11'b0_10100101_0_1, 1'b0, -10);
        run_frame("01",     8'h01, 11'b0_10000000_1_1, 1'b0, -10);
        run_frame("ff",     8'hFF, 11'b0_11111111_0_1, 1'b0, -10);
        run_frame("80_lsb", 8'h80, 11'b0_00000001_1_1, 1'b0, -10);
        run_frame("80_msb", 8'h80, 11'b0_10000000_1_1, 1'b1, -10);

        // valid held through an A5 frame with 3C waiting behind it.
        @(negedge clock);
        data_in = 8'hA5;
        valid   = 1'b1;
        @(posedge clock);
        #1 data_in = 8'h3C;
        capture(1'b0, -10, line, dline);
        check("hold_a5_line", line, expand(11'b0_10100101_0_1));
        check("hold_a5_done", dline, 44'd1);
        @(negedge clock);
        check("hold_gap_line",  so0,    1'b1);
        check("hold_gap_ready", ready0, 1'b1);
        @(posedge clock);
        #1 valid = 1'b0;
        capture(1'b0, -10, line, dline);
        check("hold_3c_line", line, expand(11'b0_00111100_0_1));
        check("hold_3c_done", dline, 44'd1);
        post_frame("hold_3c", 1'b0);
        $display("[TB] frame hold word=3c line=%011h", line);

        // Reset during data bit 3 of an A5 frame (cycles 16..19 after accept).
        accept_word(8'hA5);
        for (int i = 0; i < 18; i++) @(negedge clock);
        check("mid_busy",  busy0, 1'b1);
        check("mid_bit3",  so0,   1'b0);
        reset_L = 1'b0;
        #1;
        check("arst_line",  so0,    1'b1);
        check("arst_busy",  busy0,  1'b0);
        check("arst_ready", ready0, 1'b1);
        check("arst_done",  done0,  1'b0);
        @(negedge clock);
        reset_L = 1'b1;
        $display("[TB] mid-frame reset checked");
        run_frame("5a", 8'h5A, 11'b0_01011010_0_1, 1'b0, -10);

        // valid pulsed mid-frame must be ignored.
        run_frame("pulse", 8'h01, 11'b0_10000000_1_1, 1'b0, 10);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy0) busy_cycles++;
        end
        check("pulse_no_extra", busy_cycles, 0);
        $display("[TB] busy pulse ignored checked");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial framed transmitter, the sending end of the team's serial word path. It accepts one WIDTH-bit word through a valid/ready handshake and emits it on a single line as a frame: start bit, data bits, even-parity bit, stop bit. Each bit is held for CLKS_PER_BIT clocks. It sits between PRNG word producers and the serial pin, and pairs with the existing SIPO-based receive side.

## Interface
- WIDTH, 8: data word width; must be ≥ 2.
- CLKS_PER_BIT, 4: clocks per transmitted bit; must be ≥ 2.
- LSB_FIRST, 1: 1 = data bit 0 is sent first; 0 = data bit WIDTH-1 is sent first.

Ports:
- clock  input  1  system clock, rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- data_in  input  WIDTH  word to send; sampled only on the accept edge.
- valid  input  1  producer has a word on data_in.
- ready  output  1  block can accept a word; high only in IDLE.
- serial_out  output  1  registered line output; idle level 1.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse in the final clock of the stop bit.

## Operation
- States are IDLE → START → DATA → PARITY → STOP → IDLE.
- Accept: on a rising edge where valid && ready, the block:
  - latches data_in into the shift register;
  - computes parity = ^data_in;
  - clears the bit-period and bit-index counters;
  - enters START.
- Line level per state:
  - IDLE: 1.
  - START: 0.
  - DATA: the current shift-register output bit.
  - PARITY: the parity bit (even parity, so the data bits plus parity have an even count of 1s).
  - STOP: 1.
- Each non-IDLE state lasts exactly CLKS_PER_BIT cycles. The bit-period counter counts 0 to CLKS_PER_BIT-1, and its terminal count ("tick") advances the frame.
- DATA lasts WIDTH bit periods. The shift register shifts right (LSB_FIRST=1) or left (LSB_FIRST=0) on each tick. The bit-index counter leaves DATA after WIDTH ticks.
- valid while busy: ignored, because ready=0. data_in changes after accept have no effect.
- valid dropping while ready=1: no transfer, and the block stays in IDLE.
- No abort input. Only reset_L terminates a frame.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, serial_out=1, ready=1, busy=0, done=0;
  - counters and shift register = 0.
- Reset mid-frame: serial_out returns to 1 immediately and the frame is discarded. After release, the first edge may accept a new word.
- Edge numbering: E0 is the accept edge; En is the nth rising edge after E0 (k = 0..WIDTH-1).
  - serial_out=0 from E0 to E(CLKS_PER_BIT).
  - Data bit k from E((k+1)·CLKS_PER_BIT).
  - Parity from E((WIDTH+1)·CLKS_PER_BIT).
  - Stop from E((WIDTH+2)·CLKS_PER_BIT).
- Total frame length: (WIDTH+3)·CLKS_PER_BIT cycles.
- done is high for the single cycle ending at edge E((WIDTH+3)·CLKS_PER_BIT). After that edge the state is IDLE, with ready=1 and busy=0.
- Back-to-back frames: a word can be accepted on the first edge after returning to IDLE. The minimum idle gap between stop bit and next start bit is one cycle at level 1.
- ready and busy are decoded combinationally from the state register. serial_out is registered, so it has no glitches.

## Structure
- Package serial_tx_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants LINE_IDLE=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module bit_timer, parameterised by CLKS_PER_BIT:
  - counter of width $clog2(CLKS_PER_BIT) with synchronous restart input and asynchronous reset_L;
  - outputs tick on its terminal count.
- The top module holds:
  - the FSM;
  - the bit-index counter, width $clog2(WIDTH+1);
  - the shift register and parity flop.

## Test plan
All scenarios use WIDTH=8 and CLKS_PER_BIT=4 unless noted.
- Send 8'hA5 with LSB_FIRST=1 → serial_out is 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each held 4 cycles. done is high in cycle 44 after accept, and ready=1 after E44.
- Send 8'h01 → parity bit = 1. Send 8'hFF → parity bit = 0. Frame length is 44 cycles in both cases.
- Send 8'h80 with LSB_FIRST=0 → the first data bit is 1 and the rest are 0. With LSB_FIRST=1 the same word gives a last data bit of 1 and the rest 0.
- Hold valid=1 with data 8'h3C during an 8'hA5 frame → 8'h3C is accepted only on the first edge after done. The line stays 1 for exactly 1 cycle between frames, and the second frame carries 8'h3C.
- Assert reset_L=0 during data bit 3 → serial_out=1, busy=0, ready=1 immediately. After release, 8'h5A is sent as a clean 44-cycle frame.
- Pulse valid for 1 cycle while busy → no extra frame, and done pulses exactly once.
